// File: rtl/qpsk_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : qpsk_ctrl_pkg                                                   |
// | Purpose  : Shared types and constants for the QPSK run controller:         |
// |            FSM state encoding, control-word bit map and source select.     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package qpsk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_TX_ON    = 3'd2,
    ST_RX_ON    = 3'd3,
    ST_MEAS     = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Control word layout, shared by the VIO word and the board switches.
  localparam int SW_W         = 4;
  localparam int SW_PHASE_LSB = 0;
  localparam int SW_PHASE_MSB = 1;
  localparam int SW_CONT      = 2;
  localparam int SW_STOP      = 3;

  localparam logic SRC_BOARD = 1'b0;
  localparam logic SRC_VIO   = 1'b1;

  // A run is in progress from reset hold up to the end of the measurement.
  function automatic logic is_busy(input state_t s);
    return (s == ST_RST_HOLD) || (s == ST_TX_ON) || (s == ST_RX_ON) || (s == ST_MEAS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/qpsk_run_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : qpsk_run_ctrl_if                                                |
// | Purpose  : Control/status bundle between the VIO + board inputs and the    |
// |            run controller.                                                 |
// | Ports    : i_sel_vio, i_vio_sw[3:0], i_vio_start, i_board_sw[3:0],         |
// |            i_board_btn (controller inputs); o_sys_reset, o_tx_enb,         |
// |            o_rx_enb, o_ber_enb, o_phase[1:0], o_win_pulse, o_busy, o_done, |
// |            o_led[3:0] (controller outputs).                                |
// |            slave modport = controller side, master = driver side.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface qpsk_run_ctrl_if;
  import qpsk_ctrl_pkg::*;

  logic            i_sel_vio;
  logic [SW_W-1:0] i_vio_sw;
  logic            i_vio_start;
  logic [SW_W-1:0] i_board_sw;
  logic            i_board_btn;

  logic            o_sys_reset;
  logic            o_tx_enb;
  logic            o_rx_enb;
  logic            o_ber_enb;
  logic [1:0]      o_phase;
  logic            o_win_pulse;
  logic            o_busy;
  logic            o_done;
  logic [3:0]      o_led;

  modport master (
    output i_sel_vio, i_vio_sw, i_vio_start, i_board_sw, i_board_btn,
    input  o_sys_reset, o_tx_enb, o_rx_enb, o_ber_enb, o_phase,
           o_win_pulse, o_busy, o_done, o_led
  );

  modport slave (
    input  i_sel_vio, i_vio_sw, i_vio_start, i_board_sw, i_board_btn,
    output o_sys_reset, o_tx_enb, o_rx_enb, o_ber_enb, o_phase,
           o_win_pulse, o_busy, o_done, o_led
  );

endinterface
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_debounce                                                   |
// | Purpose  : 2-FF synchroniser followed by a per-bit stability filter. A new |
// |            level is accepted after DB_CYCLES consecutive synchronised      |
// |            samples that differ from the current output.                    |
// | Ports    : i_clk, i_reset (async, active-low), i_din[W-1:0] (async),       |
// |            o_dout[W-1:0] (filtered, i_clk domain, resets to 0)             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sync_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int W         = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_bit
    logic [CW-1:0] r_cnt;
    logic          r_q;

    // Any sample equal to the accepted level restarts the run, so only an
    // unbroken run of the opposite level gets through.
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        r_cnt <= '0;
        r_q   <= 1'b0;
      end else if (r_sync[g] == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_cnt <= '0;
        r_q   <= r_sync[g];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign o_dout[g] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/qpsk_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : qpsk_run_ctrl                                                   |
// | Purpose  : Run controller for qpsk_comm_sys. Selects VIO or board as the   |
// |            control source and sequences one measurement run:             |
// |            reset hold -> TX on -> RX on -> BER window (optionally looped).|
// | Ports    : i_clk   - system clock                                          |
// |            i_reset - asynchronous active-low reset                         |
// |            ctrl    - qpsk_run_ctrl_if.slave (source inputs, run outputs)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module qpsk_run_ctrl
  import qpsk_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MEAS_CYCLES   = 1048576,
  parameter int DB_CYCLES     = 4,
  parameter int CNT_W         = 24
) (
  input  logic           i_clk,
  input  logic           i_reset,
  qpsk_run_ctrl_if.slave ctrl
);

  localparam longint MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? longint'(RST_CYCLES)
                                                          : longint'(SETTLE_CYCLES);
  localparam longint MAX_N = (MAX_A > longint'(MEAS_CYCLES)) ? MAX_A : longint'(MEAS_CYCLES);

  if ((MAX_N - 1) >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
    $error("qpsk_run_ctrl: CNT_W too small for the longest phase");
  end

  // Board inputs: {button, switches} through sync + debounce.
  logic [SW_W:0] w_board_db;

  sync_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .W         (SW_W + 1)
  ) u_board_db (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_din  ({ctrl.i_board_btn, ctrl.i_board_sw}),
    .o_dout (w_board_db)
  );

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_src;
  logic             r_vio_start_d;
  logic             r_btn_d;
  logic [1:0]       r_phase;
  logic [1:0]       w_phase_nx;
  logic             r_cont;
  logic             w_cont_nx;
  logic             r_sys_reset;
  logic             r_tx_enb;
  logic             r_rx_enb;
  logic             r_ber_enb;
  logic             r_win_pulse;
  logic             w_win_nx;
  logic             r_busy;
  logic             r_done;

  logic [SW_W-1:0]  w_sw;
  logic             w_start;
  logic             w_stop;
  logic             w_idle_like;

  // Separate edge detectors per source so a source switch never looks like an edge.
  assign w_sw        = (r_src == SRC_VIO) ? ctrl.i_vio_sw : w_board_db[SW_W-1:0];
  assign w_start     = (r_src == SRC_VIO) ? (ctrl.i_vio_start & ~r_vio_start_d)
                                          : (w_board_db[SW_W] & ~r_btn_d);
  assign w_stop      = w_sw[SW_STOP];
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_phase_nx = r_phase;
    w_cont_nx  = r_cont;
    w_win_nx   = 1'b0;

    if (w_stop) begin
      // Stop overrides everything, including a start in the same cycle.
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
      w_phase_nx = 2'b00;
      w_cont_nx  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            w_state_nx = ST_RST_HOLD;
            w_cnt_nx   = CNT_W'(RST_CYCLES - 1);
            w_phase_nx = w_sw[SW_PHASE_MSB:SW_PHASE_LSB];
            w_cont_nx  = w_sw[SW_CONT];
          end
        end
        ST_RST_HOLD: begin
          if (r_cnt == '0) begin
            w_state_nx = ST_TX_ON;
            w_cnt_nx   = CNT_W'(SETTLE_CYCLES - 1);
          end else begin
            w_cnt_nx = r_cnt - CNT_W'(1);
          end
        end
        ST_TX_ON: begin
          if (r_cnt == '0) begin
            w_state_nx = ST_RX_ON;
            w_cnt_nx   = CNT_W'(SETTLE_CYCLES - 1);
          end else begin
            w_cnt_nx = r_cnt - CNT_W'(1);
          end
        end
        ST_RX_ON: begin
          if (r_cnt == '0) begin
            w_state_nx = ST_MEAS;
            w_cnt_nx   = CNT_W'(MEAS_CYCLES - 1);
          end else begin
            w_cnt_nx = r_cnt - CNT_W'(1);
          end
        end
        ST_MEAS: begin
          if (r_cnt == '0) begin
            w_win_nx = 1'b1;
            if (r_cont) begin
              w_cnt_nx = CNT_W'(MEAS_CYCLES - 1);
            end else begin
              w_state_nx = ST_DONE;
            end
          end else begin
            w_cnt_nx = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_src         <= SRC_BOARD;
      r_vio_start_d <= 1'b0;
      r_btn_d       <= 1'b0;
      r_phase       <= 2'b00;
      r_cont        <= 1'b0;
      r_sys_reset   <= 1'b1;
      r_tx_enb      <= 1'b0;
      r_rx_enb      <= 1'b0;
      r_ber_enb     <= 1'b0;
      r_win_pulse   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_vio_start_d <= ctrl.i_vio_start;
      r_btn_d       <= w_board_db[SW_W];
      r_phase       <= w_phase_nx;
      r_cont        <= w_cont_nx;
      r_sys_reset   <= (w_state_nx == ST_IDLE) || (w_state_nx == ST_RST_HOLD);
      r_tx_enb      <= (w_state_nx == ST_TX_ON) || (w_state_nx == ST_RX_ON) ||
                       (w_state_nx == ST_MEAS)  || (w_state_nx == ST_DONE);
      r_rx_enb      <= (w_state_nx == ST_RX_ON) || (w_state_nx == ST_MEAS) ||
                       (w_state_nx == ST_DONE);
      r_ber_enb     <= (w_state_nx == ST_MEAS);
      r_win_pulse   <= w_win_nx;
      r_busy        <= is_busy(w_state_nx);
      r_done        <= (w_state_nx == ST_DONE);
      // A source change requested mid-run waits until the run has ended.
      if (w_idle_like) begin
        r_src <= ctrl.i_sel_vio;
      end
    end
  end

  assign ctrl.o_sys_reset = r_sys_reset;
  assign ctrl.o_tx_enb    = r_tx_enb;
  assign ctrl.o_rx_enb    = r_rx_enb;
  assign ctrl.o_ber_enb   = r_ber_enb;
  assign ctrl.o_phase     = r_phase;
  assign ctrl.o_win_pulse = r_win_pulse;
  assign ctrl.o_busy      = r_busy;
  assign ctrl.o_done      = r_done;
  assign ctrl.o_led       = {r_busy, r_done, r_phase};

endmodule
`default_nettype wire

// File: tb/tb_qpsk_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_qpsk_run_ctrl                                                |
// | Purpose  : Self-checking bench for qpsk_run_ctrl (short phase lengths).    |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_qpsk_run_ctrl;

  logic clk;
  logic rst_n;

  qpsk_run_ctrl_if ctrl_if ();

  qpsk_run_ctrl #(
    .RST_CYCLES   (4),
    .SETTLE_CYCLES(8),
    .MEAS_CYCLES  (16),
    .DB_CYCLES    (3),
    .CNT_W        (8)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .ctrl   (ctrl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row: at cycle k (counted from the row-0 cycle) compare outputs, then drive inputs.
  typedef struct {
    int         k;
    logic [3:0] vio_sw;
    logic       vio_start;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   kk;

  // {sys_reset, tx, rx, ber, win, busy, done, phase, led}
  function automatic logic [12:0] mk(input logic sr, tx, rx, ber, win, busy, done,
                                     input logic [1:0] ph);
    return {sr, tx, rx, ber, win, busy, done, ph, busy, done, ph};
  endfunction

  function automatic logic [12:0] outs();
    return {ctrl_if.o_sys_reset, ctrl_if.o_tx_enb, ctrl_if.o_rx_enb, ctrl_if.o_ber_enb,
            ctrl_if.o_win_pulse, ctrl_if.o_busy, ctrl_if.o_done, ctrl_if.o_phase,
            ctrl_if.o_led};
  endfunction

  task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (sr,tx,rx,ber,win,busy,done,ph,led)", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int target);
    while (kk < target) begin
      step();
      kk++;
    end
  endtask

  task automatic add(input int k, input logic [3:0] sw, input logic st, input logic [12:0] e);
    vec_t v;
    v.k = k; v.vio_sw = sw; v.vio_start = st; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string nm);
    kk = 0;
    foreach (tbl[i]) begin
      go(tbl[i].k);
      check($sformatf("%s k=%0d", nm, tbl[i].k), outs(), tbl[i].exp);
      ctrl_if.i_vio_sw    = tbl[i].vio_sw;
      ctrl_if.i_vio_start = tbl[i].vio_start;
    end
  endtask

  task automatic do_reset(input logic sel_vio);
    rst_n               = 1'b0;
    ctrl_if.i_sel_vio   = sel_vio;
    ctrl_if.i_vio_sw    = 4'b0000;
    ctrl_if.i_vio_start = 1'b0;
    ctrl_if.i_board_sw  = 4'b0000;
    ctrl_if.i_board_btn = 1'b0;
    step();
    step();
    check("reset_values", outs(), mk(1, 0, 0, 0, 0, 0, 0, 2'd0));
    rst_n = 1'b1;
    step();
    step();
  endtask

  logic [12:0] idle_v;

  initial begin
    int runs;
    logic prev_busy;
    idle_v = mk(1, 0, 0, 0, 0, 0, 0, 2'd0);

    // Single VIO run, phase 2.
    do_reset(1'b1);
    tbl.delete();
    add(0,  4'b0010, 1'b1, idle_v);
    add(1,  4'b0010, 1'b1, mk(1, 0, 0, 0, 0, 1, 0, 2'd2));
    add(4,  4'b0010, 1'b1, mk(1, 0, 0, 0, 0, 1, 0, 2'd2));
    add(5,  4'b0010, 1'b1, mk(0, 1, 0, 0, 0, 1, 0, 2'd2));
    add(12, 4'b0010, 1'b1, mk(0, 1, 0, 0, 0, 1, 0, 2'd2));
    add(13, 4'b0010, 1'b1, mk(0, 1, 1, 0, 0, 1, 0, 2'd2));
    add(20, 4'b0010, 1'b1, mk(0, 1, 1, 0, 0, 1, 0, 2'd2));
    add(21, 4'b0010, 1'b1, mk(0, 1, 1, 1, 0, 1, 0, 2'd2));
    add(36, 4'b0010, 1'b1, mk(0, 1, 1, 1, 0, 1, 0, 2'd2));
    add(37, 4'b0010, 1'b1, mk(0, 1, 1, 0, 1, 0, 1, 2'd2));
    add(38, 4'b0010, 1'b1, mk(0, 1, 1, 0, 0, 0, 1, 2'd2));
    run_table("single_run");

    // Continuous mode, then stop; start edge while stop held is ignored.
    do_reset(1'b1);
    tbl.delete();
    add(0,  4'b0111, 1'b1, idle_v);
    add(21, 4'b0111, 1'b1, mk(0, 1, 1, 1, 0, 1, 0, 2'd3));
    add(36, 4'b0111, 1'b1, mk(0, 1, 1, 1, 0, 1, 0, 2'd3));
    add(37, 4'b0111, 1'b1, mk(0, 1, 1, 1, 1, 1, 0, 2'd3));
    add(38, 4'b0111, 1'b1, mk(0, 1, 1, 1, 0, 1, 0, 2'd3));
    add(53, 4'b0111, 1'b1, mk(0, 1, 1, 1, 1, 1, 0, 2'd3));
    add(69, 4'b0111, 1'b1, mk(0, 1, 1, 1, 1, 1, 0, 2'd3));
    add(70, 4'b1111, 1'b0, mk(0, 1, 1, 1, 0, 1, 0, 2'd3));
    add(71, 4'b1111, 1'b1, idle_v);
    add(72, 4'b1111, 1'b1, idle_v);
    add(76, 4'b0111, 1'b1, idle_v);
    add(80, 4'b0111, 1'b1, idle_v);
    run_table("continuous");

    // Stop and start together in IDLE.
    do_reset(1'b1);
    tbl.delete();
    add(0, 4'b1000, 1'b1, idle_v);
    add(1, 4'b1000, 1'b1, idle_v);
    add(5, 4'b0000, 1'b1, idle_v);
    add(9, 4'b0000, 1'b1, idle_v);
    run_table("stop_start");

    // Board button with bounce 1-0-1; start seen after sync (2) + debounce (3).
    do_reset(1'b0);
    ctrl_if.i_board_sw = 4'b0001;
    repeat (10) step();
    ctrl_if.i_board_btn = 1'b1;
    step();
    ctrl_if.i_board_btn = 1'b0;
    step();
    ctrl_if.i_board_btn = 1'b1;             // last edge, cycle L
    repeat (5) step();
    check("board_L+5", outs(), idle_v);
    step();
    check("board_L+6", outs(), mk(1, 0, 0, 0, 0, 1, 0, 2'd1));
    runs = 1;
    prev_busy = 1'b1;
    repeat (60) begin
      step();
      if (ctrl_if.o_busy && !prev_busy) runs++;
      prev_busy = ctrl_if.o_busy;
    end
    n_cmp++;
    if (runs != 1) begin
      n_fail++;
      $display("FAIL board_run_count: got %0d runs want 1", runs);
    end
    check("board_done", outs(), mk(0, 1, 1, 0, 0, 0, 1, 2'd1));

    // Source/start/phase changes mid-run are deferred or ignored.
    do_reset(1'b1);
    kk = 0;
    ctrl_if.i_vio_sw    = 4'b0010;
    ctrl_if.i_vio_start = 1'b1;
    go(10);
    ctrl_if.i_sel_vio   = 1'b0;
    ctrl_if.i_vio_start = 1'b0;
    ctrl_if.i_vio_sw    = 4'b0001;
    go(12);
    ctrl_if.i_vio_start = 1'b1;
    go(13);
    check("defer_rx", outs(), mk(0, 1, 1, 0, 0, 1, 0, 2'd2));
    go(21);
    check("defer_meas", outs(), mk(0, 1, 1, 1, 0, 1, 0, 2'd2));
    go(37);
    check("defer_done", outs(), mk(0, 1, 1, 0, 1, 0, 1, 2'd2));
    go(40);
    ctrl_if.i_vio_start = 1'b0;
    go(42);
    ctrl_if.i_vio_start = 1'b1;             // VIO no longer the source
    go(46);
    check("defer_vio_ignored", outs(), mk(0, 1, 1, 0, 0, 0, 1, 2'd2));
    ctrl_if.i_board_btn = 1'b1;
    go(51);
    check("defer_board_wait", outs(), mk(0, 1, 1, 0, 0, 0, 1, 2'd2));
    go(52);
    check("defer_board_restart", outs(), mk(1, 0, 0, 0, 0, 1, 0, 2'd0));
    ctrl_if.i_board_btn = 1'b0;

    // Asynchronous reset during RX_ON.
    do_reset(1'b1);
    kk = 0;
    ctrl_if.i_vio_sw    = 4'b0011;
    ctrl_if.i_vio_start = 1'b1;
    go(15);
    check("async_pre", outs(), mk(0, 1, 1, 0, 0, 1, 0, 2'd3));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), idle_v);
    step();
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check("async_stay_idle", outs(), idle_v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
